// File: rtl/sram_responder.sv
// Data-side SRAM responder: byte-lane RAM plus LED/switch/timer/scratch/write-count registers.
// Single-cycle registered read (read-before-write); accepts an access every cycle, never stalls.
module sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'h1faf_0000,
  parameter int          SW_W      = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [3:0]      wen,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [15:0]     led,
  input  logic [SW_W-1:0] sw
);

  localparam int         DEPTH       = 1 << RAM_AW;
  localparam logic [13:0] OFF_LED     = 14'h0;
  localparam logic [13:0] OFF_SWITCH  = 14'h1;
  localparam logic [13:0] OFF_TIMER   = 14'h2;
  localparam logic [13:0] OFF_SCRATCH = 14'h3;
  localparam logic [13:0] OFF_WCOUNT  = 14'h4;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [31:0]       wcount_q, wcount_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;

  logic              conf_hit, is_wr, ram_we;
  logic [13:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_word, conf_rd;
  logic              unused_addr;

  assign conf_hit    = (addr[31:16] == CONF_BASE[31:16]);
  assign is_wr       = en && (wen != 4'b0000);
  assign ram_we      = is_wr && !conf_hit;
  assign off         = addr[15:2];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign ram_word    = mem[ram_idx];
  assign unused_addr = ^addr[1:0];

  always_comb begin
    conf_rd = '0;
    case (off)
      OFF_LED:     conf_rd = {16'h0000, led_q};
      OFF_SWITCH:  conf_rd[SW_W-1:0] = sw_s2_q;
      OFF_TIMER:   conf_rd = timer_q;
      OFF_SCRATCH: conf_rd = scratch_q;
      OFF_WCOUNT:  conf_rd = wcount_q;
      default:     conf_rd = '0;
    endcase
  end

  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    wcount_d  = wcount_q;

    // Captured from pre-edge state, so writes in the same access read back the old value.
    if (en) begin
      rdata_d = conf_hit ? conf_rd : ram_word;
    end

    if (is_wr && conf_hit) begin
      case (off)
        OFF_LED: begin
          led_d[7:0]  = wen[0] ? wdata[7:0]  : led_q[7:0];
          led_d[15:8] = wen[1] ? wdata[15:8] : led_q[15:8];
        end
        OFF_TIMER:   timer_d   = lane_merge(timer_q, wdata, wen);
        OFF_SCRATCH: scratch_d = lane_merge(scratch_q, wdata, wen);
        default: ;
      endcase
    end

    if (ram_we && (wcount_q != 32'hFFFF_FFFF)) begin
      wcount_d = wcount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      scratch_q <= '0;
      wcount_q  <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      wcount_q  <= wcount_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
    end
  end

  // RAM is not reset, but a write must not land while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && resetn) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign led   = led_q;

endmodule
